reaction_timer_ctrl: RTL and testbench

- Control FSM for the reaction-time experiment. It sits directly downstream of the 1 ms tick divider and consumes its single-cycle tick.
- On a start pulse it waits a pseudo-random number of milliseconds, then lights the LED. It counts elapsed milliseconds in 4-digit BCD until stop.
- It holds the result for the 7-segment display path and flags false starts and timeouts.

---
 rtl/reaction_timer_ctrl.sv | 150 +++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time experiment controller: random pre-delay, LED stimulus, BCD millisecond
// count until stop, with false-start and timeout flagging.
module reaction_timer_ctrl #(
    parameter int DELAY_W   = 14,
    parameter int MIN_DELAY = 1000,
    parameter int MAX_DELAY = 5000
) (
    input  logic               clock,
    input  logic               sreset,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic [DELAY_W-1:0] rand_delay,
    output logic               led,
    output logic [15:0]        time_bcd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ARMED,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [15:0]        time_q, time_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [15:0]        time_inc;

    function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] r);
        if (r < DELAY_W'(MIN_DELAY)) return DELAY_W'(MIN_DELAY);
        if (r > DELAY_W'(MAX_DELAY)) return DELAY_W'(MAX_DELAY);
        return r;
    endfunction

    // Ripple a +1 through four decimal digits, each wrapping 9 -> 0.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign time_inc = bcd_inc(time_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        time_d  = time_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = clamp_delay(rand_delay);
                    time_d  = 16'h0000;
                    led_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_HOLD;
                    time_d  = 16'h0000;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (tick) begin
                    if (cnt_q == DELAY_W'(1)) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                        led_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DELAY_W'(1);
                    end
                end
            end
            S_ARMED: begin
                // stop outranks a coincident tick: that millisecond is not counted
                if (stop) begin
                    state_d = S_HOLD;
                    led_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (tick) begin
                    time_d = time_inc;
                    if (time_inc == 16'h9999) begin
                        state_d = S_HOLD;
                        led_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            time_q  <= 16'h0000;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            time_q  <= time_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign led      = led_q;
    assign time_bcd = time_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: vector table, directed corner sequences, and random
// traffic compared each cycle against a millisecond-level reference model.
module tb_reaction_timer_ctrl;

    localparam int DW   = 14;
    localparam int MIND = 2;
    localparam int MAXD = 10;

    logic          clock = 1'b0;
    logic          sreset = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] rand_delay = '0;
    logic          led;
    logic [15:0]   time_bcd;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;

    reaction_timer_ctrl #(.DELAY_W(DW), .MIN_DELAY(MIND), .MAX_DELAY(MAXD)) dut (
        .clock(clock), .sreset(sreset), .tick(tick), .start(start), .stop(stop),
        .rand_delay(rand_delay), .led(led), .time_bcd(time_bcd), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Reference model: experiment phase, milliseconds left before the light, elapsed ms.
    typedef enum int { PH_IDLE, PH_WAIT, PH_LIT, PH_RESULT } phase_t;
    phase_t m_phase = PH_IDLE;
    int     m_left = 0;
    int     m_ms = 0;
    bit     m_bad = 0;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int clamp_ref(input int r);
        return (r < MIND) ? MIND : ((r > MAXD) ? MAXD : r);
    endfunction

    task automatic model_update();
        if (sreset) begin
            m_phase = PH_IDLE; m_left = 0; m_ms = 0; m_bad = 0;
        end else if ((m_phase == PH_IDLE || m_phase == PH_RESULT) && start) begin
            m_phase = PH_WAIT; m_left = clamp_ref(int'(rand_delay)); m_ms = 0; m_bad = 0;
        end else if (m_phase == PH_WAIT && stop) begin
            m_phase = PH_RESULT; m_ms = 0; m_bad = 1;
        end else if (m_phase == PH_WAIT && tick) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = PH_LIT;
        end else if (m_phase == PH_LIT && stop) begin
            m_phase = PH_RESULT; m_bad = 0;
        end else if (m_phase == PH_LIT && tick) begin
            m_ms = m_ms + 1;
            if (m_ms == 9999) begin m_phase = PH_RESULT; m_bad = 1; end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_led",  32'(led),      32'(m_phase == PH_LIT));
        chk("m_busy", 32'(busy),     32'(m_phase == PH_WAIT || m_phase == PH_LIT));
        chk("m_done", 32'(done),     32'(m_phase == PH_RESULT));
        chk("m_err",  32'(err),      32'(m_bad));
        chk("m_time", 32'(time_bcd), 32'(to_bcd(m_ms)));
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic pulse_tick(input int gap);
        tick = 1'b1; step(); tick = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic start_run(input int rd);
        start = 1'b1; rand_delay = DW'(rd); step(); start = 1'b0;
    endtask

    task automatic count_to_led(output int n);
        n = -1;
        for (int i = 1; i <= 30 && n < 0; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (led) n = i;
        end
    endtask

    typedef struct {
        bit          rst, st, sp, tk;
        int          rd;
        bit          e_led, e_busy, e_done, e_err;
        logic [15:0] e_time;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n;
        bit lit;
        //            rst st sp tk rd   led bsy dn er time
        vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000};
        vecs[1]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000};
        vecs[2]  = '{0, 0, 0, 1, 0,   0, 0, 0, 0, 16'h0000};
        vecs[3]  = '{0, 0, 1, 0, 0,   0, 0, 0, 0, 16'h0000};
        vecs[4]  = '{0, 0, 0, 1, 0,   0, 0, 0, 0, 16'h0000};
        vecs[5]  = '{0, 1, 0, 0, 0,   0, 1, 0, 0, 16'h0000};
        vecs[6]  = '{0, 0, 0, 1, 0,   0, 1, 0, 0, 16'h0000};
        vecs[7]  = '{0, 0, 0, 0, 0,   0, 1, 0, 0, 16'h0000};
        vecs[8]  = '{0, 0, 0, 1, 0,   1, 1, 0, 0, 16'h0000};
        vecs[9]  = '{0, 1, 0, 0, 7,   1, 1, 0, 0, 16'h0000};
        vecs[10] = '{0, 0, 0, 1, 0,   1, 1, 0, 0, 16'h0001};
        vecs[11] = '{0, 0, 1, 1, 0,   0, 0, 1, 0, 16'h0001};
        vecs[12] = '{0, 0, 0, 1, 0,   0, 0, 1, 0, 16'h0001};
        vecs[13] = '{0, 1, 1, 0, 200, 0, 1, 0, 0, 16'h0000};
        vecs[14] = '{0, 0, 1, 0, 0,   0, 0, 1, 1, 16'h0000};
        vecs[15] = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000};
        for (int i = 0; i < 16; i++) begin
            sreset = vecs[i].rst; start = vecs[i].st; stop = vecs[i].sp;
            tick = vecs[i].tk; rand_delay = DW'(vecs[i].rd);
            step();
            chk($sformatf("vec%0d_led", i),  32'(led),      32'(vecs[i].e_led));
            chk($sformatf("vec%0d_busy", i), 32'(busy),     32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_done", i), 32'(done),     32'(vecs[i].e_done));
            chk($sformatf("vec%0d_err", i),  32'(err),      32'(vecs[i].e_err));
            chk($sformatf("vec%0d_time", i), 32'(time_bcd), 32'(vecs[i].e_time));
        end
        sreset = 0; start = 0; stop = 0; tick = 0;

        // rand_delay=5 with a tick every 4 clocks, then 7 counted ticks and stop
        start_run(5);
        repeat (4) pulse_tick(4);
        chk("d5_led_before", 32'(led), 32'd0);
        tick = 1'b1; step(); tick = 1'b0;
        chk("d5_led_after5", 32'(led), 32'd1);
        repeat (3) step();
        repeat (7) pulse_tick(4);
        stop = 1'b1; step(); stop = 1'b0;
        chk("d5_time", 32'(time_bcd), 32'h0007);
        chk("d5_done", 32'(done), 32'd1);
        chk("d5_err",  32'(err), 32'd0);
        chk("d5_led",  32'(led), 32'd0);

        // clamp both ends
        start_run(0);
        count_to_led(n);
        chk("clamp_lo_ticks", 32'(n), 32'd2);
        stop = 1'b1; step(); stop = 1'b0;
        start_run(200);
        count_to_led(n);
        chk("clamp_hi_ticks", 32'(n), 32'd10);
        stop = 1'b1; step(); stop = 1'b0;

        // false start
        start_run(5);
        lit = 0;
        for (int i = 0; i < 3; i++) begin
            pulse_tick(2);
            if (led) lit = 1;
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("fs_led_never", 32'(lit), 32'd0);
        chk("fs_err",  32'(err), 32'd1);
        chk("fs_done", 32'(done), 32'd1);
        chk("fs_time", 32'(time_bcd), 32'h0000);

        // BCD carry and timeout, tick every clock
        start_run(2);
        repeat (2) pulse_tick(1);
        tick = 1'b1;
        repeat (9) step();
        chk("bcd_9", 32'(time_bcd), 32'h0009);
        step();
        chk("bcd_10", 32'(time_bcd), 32'h0010);
        repeat (9989) step();
        chk("to_time", 32'(time_bcd), 32'h9999);
        chk("to_done", 32'(done), 32'd1);
        chk("to_err",  32'(err), 32'd1);
        chk("to_led",  32'(led), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        repeat (5) step();
        chk("to_frozen", 32'(time_bcd), 32'h9999);
        tick = 1'b0;

        // stop and tick together in ARMED
        start_run(2);
        repeat (2) pulse_tick(1);
        tick = 1'b1; repeat (41) step(); tick = 1'b0;
        chk("pri_pre", 32'(time_bcd), 32'h0041);
        stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
        chk("pri_time", 32'(time_bcd), 32'h0041);
        chk("pri_done", 32'(done), 32'd1);

        // start while ARMED ignored, start from HOLD restarts
        start_run(2);
        repeat (2) pulse_tick(1);
        repeat (3) pulse_tick(1);
        start_run(9);
        chk("rs_ign_led",  32'(led), 32'd1);
        chk("rs_ign_time", 32'(time_bcd), 32'h0003);
        stop = 1'b1; step(); stop = 1'b0;
        start_run(3);
        chk("rs_time", 32'(time_bcd), 32'h0000);
        chk("rs_err",  32'(err), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        count_to_led(n);
        chk("rs_ticks", 32'(n), 32'd3);

        // mid-run reset in ARMED
        repeat (5) pulse_tick(1);
        sreset = 1'b1; step(); sreset = 1'b0;
        chk("mr_led",  32'(led), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_err",  32'(err), 32'd0);
        chk("mr_time", 32'(time_bcd), 32'h0000);

        // random traffic against the model, plus structural invariants
        for (int c = 0; c < 4000; c++) begin
            sreset     = ($urandom_range(0, 499) == 0);
            start      = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            tick       = ($urandom_range(0, 1) == 1);
            rand_delay = DW'($urandom_range(0, 15));
            step();
            chk("inv_busy_done", 32'(busy & done), 32'd0);
            chk("inv_led_busy",  32'(led & ~busy), 32'd0);
            for (int d = 0; d < 4; d++)
                if (time_bcd[d*4 +: 4] > 4'd9) chk("inv_digit", 32'(time_bcd), 32'(to_bcd(m_ms)));
        end
        sreset = 0; start = 0; stop = 0; tick = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
